sha1_tag_dispatch: RTL and testbench

Issue side of the SHA1 result-ordering scheme: accepts hash jobs from the upstream job queue, stamps each with a sequential tag, and launches it on a free SHA1 engine chosen round-robin. Limits outstanding tags to the result reorder buffer depth, using a credit returned each time the in-order result reader pops an entry. Sits between the job queue and the engine array, opposite the result reorder buffer.

---
 rtl/sha1_pkg.sv | 17 +
 rtl/sha1_rr_arbiter.sv | 51 +++++
 rtl/sha1_tag_dispatch.sv | 156 +++++++++++++++
 tb/tb_sha1_tag_dispatch.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha1_pkg.sv
// Shared SHA1 result-ordering definitions: dispatcher FSM states and tag/ROB sizing.
// Latency: none (types and constants only).
// Backpressure: n/a.
package sha1_pkg;

  // Dispatcher control states
  typedef enum logic [1:0] {
    ST_WAIT_INIT = 2'd0,
    ST_IDLE      = 2'd1,
    ST_ISSUE     = 2'd2
  } disp_state_e;

  // Defaults shared with the result reorder buffer so both sides agree on sizing
  localparam int SHA1_TAG_WIDTH       = 10;
  localparam int SHA1_MAX_OUTSTANDING = 1024;

endpackage

// File: rtl/sha1_rr_arbiter.sv
// Round-robin pick of one requesting engine, search starting after the last grant.
// Latency: grant is combinational from req; pointer updates on the clock after advance.
// Backpressure: none; grant is all-zero when nothing requests.
module sha1_rr_arbiter #(
  parameter int ENGINE_NUM = 4,
  parameter int IDX_W      = $clog2(ENGINE_NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ENGINE_NUM-1:0] req,
  input  logic                  advance,
  output logic [ENGINE_NUM-1:0] grant,
  output logic [IDX_W-1:0]      grant_idx
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] cand;
  logic             found;

  // First requester at or after the pointer, wrapping around the engine array
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < ENGINE_NUM; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % ENGINE_NUM);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

  // Move the pointer one past the engine just granted
  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (grant_idx == IDX_W'(ENGINE_NUM - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Priority pointer register; engine 0 is searched first after reset
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sha1_tag_dispatch.sv
// Stamps upstream hash jobs with sequential tags and launches them round-robin on free SHA1 engines.
// Latency: accept in cycle N, engine launch strobe in N+1; at most one job per 2 cycles.
// Backpressure: job_ready low until init, when no engine is free or outstanding tags reach ROB depth.
// Optional statistics counters are built when SHA1_TAG_DISPATCH_STAT_EN is defined.
module sha1_tag_dispatch
  import sha1_pkg::*;
#(
  parameter int TAG_WIDTH       = SHA1_TAG_WIDTH,
  parameter int ENGINE_NUM      = 4,
  parameter int JOB_WIDTH       = 32,
  parameter int MAX_OUTSTANDING = SHA1_MAX_OUTSTANDING,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_done,
  input  logic                  job_valid,
  input  logic [JOB_WIDTH-1:0]  job_data,
  output logic                  job_ready,
  input  logic [ENGINE_NUM-1:0] eng_busy,
  output logic [ENGINE_NUM-1:0] eng_start,
  output logic [JOB_WIDTH-1:0]  eng_data,
  output logic [TAG_WIDTH-1:0]  eng_tag,
  input  logic                  credit_ret,
  output logic [CNT_WIDTH-1:0]  outstanding,
  output logic                  credit_err,
  output logic [31:0]           stat_issue_cnt,
  output logic [31:0]           stat_stall_cnt
);

  localparam int IDX_W = $clog2(ENGINE_NUM);

  disp_state_e           state_q;
  logic [ENGINE_NUM-1:0] eng_start_q;
  logic [JOB_WIDTH-1:0]  eng_data_q;
  logic [TAG_WIDTH-1:0]  eng_tag_q;
  logic [TAG_WIDTH-1:0]  next_tag_q;
  logic [CNT_WIDTH-1:0]  outstanding_q;
  logic [CNT_WIDTH-1:0]  outstanding_d;
  logic                  credit_err_q;
  logic                  credit_err_d;

  logic [ENGINE_NUM-1:0] arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic                  issue;
  logic                  can_issue;

  // The pointer advances at accept: the next accept can only happen after the
  // launch cycle, so the effect matches moving it at launch, and the grant is
  // frozen in eng_start_q regardless of later eng_busy changes.
  sha1_rr_arbiter #(
    .ENGINE_NUM (ENGINE_NUM),
    .IDX_W      (IDX_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (~eng_busy),
    .advance   (job_ready),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign issue     = (state_q == ST_ISSUE);
  // arb_grant is non-zero exactly when some engine is free
  assign can_issue = (outstanding_q < CNT_WIDTH'(MAX_OUTSTANDING)) && (|arb_grant);
  assign job_ready = (state_q == ST_IDLE) && job_valid && can_issue;

  // Control FSM with registered launch outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT_INIT;
      eng_start_q <= '0;
      eng_data_q  <= '0;
      eng_tag_q   <= '0;
      next_tag_q  <= '0;
    end else begin
      eng_start_q <= '0;
      case (state_q)
        ST_WAIT_INIT: begin
          if (init_done) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (job_ready) begin
            eng_start_q <= ENGINE_NUM'(1) << arb_idx;
            eng_data_q  <= job_data;
            eng_tag_q   <= next_tag_q;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          next_tag_q <= next_tag_q + 1'b1;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_WAIT_INIT;
      endcase
    end
  end

  // Outstanding tag count: issue adds, credit removes; a credit with nothing
  // outstanding (and no launch this cycle) is an upstream error, latched sticky
  always_comb begin
    outstanding_d = outstanding_q;
    credit_err_d  = credit_err_q;
    if (issue && !credit_ret) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!issue && credit_ret) begin
      if (outstanding_q == '0) credit_err_d  = 1'b1;
      else                     outstanding_d = outstanding_q - 1'b1;
    end
  end

  // Credit bookkeeping registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      credit_err_q  <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      credit_err_q  <= credit_err_d;
    end
  end

  // The strobe is masked while reset is held so a job caught mid-launch by
  // reset never reaches an engine
  assign eng_start   = eng_start_q & {ENGINE_NUM{rst_n}};
  assign eng_data    = eng_data_q;
  assign eng_tag     = eng_tag_q;
  assign outstanding = outstanding_q;
  assign credit_err  = credit_err_q;

`ifdef SHA1_TAG_DISPATCH_STAT_EN
  logic [31:0] stat_issue_q;
  logic [31:0] stat_stall_q;
  logic        stall;

  assign stall = (state_q == ST_IDLE) && job_valid && !job_ready;

  // Saturating issue and stall statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_issue_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (issue && !(&stat_issue_q)) stat_issue_q <= stat_issue_q + 32'd1;
      if (stall && !(&stat_stall_q)) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_issue_cnt = stat_issue_q;
  assign stat_stall_cnt = stat_stall_q;
`else
  assign stat_issue_cnt = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sha1_tag_dispatch.sv
// Bench for sha1_tag_dispatch: directed scenarios plus random traffic against a behavioural model.
// Small configuration (3-bit tags, ROB depth 4) so limit and wrap cases are reached quickly.
// Statistics expectations follow SHA1_TAG_DISPATCH_STAT_EN.
module tb_sha1_tag_dispatch;

  localparam int TW = 3;
  localparam int EN = 4;
  localparam int JW = 32;
  localparam int MO = 4;
  localparam int CW = $clog2(MO + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_done;
  logic          job_valid;
  logic [JW-1:0] job_data;
  logic          job_ready;
  logic [EN-1:0] eng_busy;
  logic [EN-1:0] eng_start;
  logic [JW-1:0] eng_data;
  logic [TW-1:0] eng_tag;
  logic          credit_ret;
  logic [CW-1:0] outstanding;
  logic          credit_err;
  logic [31:0]   stat_issue_cnt;
  logic [31:0]   stat_stall_cnt;

  always #5 clk = ~clk;

  sha1_tag_dispatch #(
    .TAG_WIDTH       (TW),
    .ENGINE_NUM      (EN),
    .JOB_WIDTH       (JW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .init_done      (init_done),
    .job_valid      (job_valid),
    .job_data       (job_data),
    .job_ready      (job_ready),
    .eng_busy       (eng_busy),
    .eng_start      (eng_start),
    .eng_data       (eng_data),
    .eng_tag        (eng_tag),
    .credit_ret     (credit_ret),
    .outstanding    (outstanding),
    .credit_err     (credit_err),
    .stat_issue_cnt (stat_issue_cnt),
    .stat_stall_cnt (stat_stall_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Behavioural model: phase 0 = waiting for init, 1 = can accept, 2 = launch pending
  int          m_phase;
  int          m_out;
  int          m_tag;
  int          m_ptr;
  int          m_eng;
  bit          m_err;
  logic [JW-1:0] m_data;
  int          m_etag;
  longint      m_iss;
  longint      m_stall;

  int log_eng[$];
  int log_tag[$];
  int log_cyc[$];
  int all_tags[$];
  int cyc_no = 0;

  function automatic void m_reset();
    m_phase = 0; m_out = 0; m_tag = 0; m_ptr = 0; m_eng = 0;
    m_err = 0; m_data = '0; m_etag = 0; m_iss = 0; m_stall = 0;
  endfunction

  // First free engine searching from the engine after the last grant, -1 if none
  function automatic int m_pick();
    for (int i = 0; i < EN; i++) begin
      int e;
      e = (m_ptr + i) % EN;
      if (eng_busy[e] == 1'b0) return e;
    end
    return -1;
  endfunction

  function automatic bit m_ready();
    return (m_phase == 1) && job_valid && (m_out < MO) && (m_pick() >= 0);
  endfunction

  function automatic void m_step();
    bit rdy;
    bit iss;
    int g;
    if (!rst_n) begin
      m_reset();
      return;
    end
    rdy = m_ready();
    g   = m_pick();
    iss = (m_phase == 2);
`ifdef SHA1_TAG_DISPATCH_STAT_EN
    if (iss) m_iss++;
    if (m_phase == 1 && job_valid && !rdy) m_stall++;
`endif
    if (credit_ret && !iss) begin
      if (m_out == 0) m_err = 1;
      else            m_out--;
    end else if (iss && !credit_ret) begin
      m_out++;
    end
    if (iss) begin
      m_tag   = (m_tag + 1) % (1 << TW);
      m_phase = 1;
    end else if (m_phase == 0) begin
      if (init_done) m_phase = 1;
    end else if (rdy) begin
      m_eng   = g;
      m_ptr   = (g + 1) % EN;
      m_data  = job_data;
      m_etag  = m_tag;
      m_phase = 2;
    end
  endfunction

  // One clock: called at a falling edge with inputs set; checks, then advances the model
  task automatic cyc();
    logic [EN-1:0] exp_start;
    #1;
    exp_start = (m_phase == 2 && rst_n) ? EN'(1 << m_eng) : '0;
    chk("job_ready", job_ready, m_ready());
    chk("eng_start", eng_start, exp_start);
    chk("eng_data", eng_data, m_data);
    chk("eng_tag", eng_tag, m_etag);
    chk("outstanding", outstanding, m_out);
    chk("credit_err", credit_err, m_err);
    chk("stat_issue", stat_issue_cnt, m_iss);
    chk("stat_stall", stat_stall_cnt, m_stall);
    if (eng_start != '0) begin
      for (int i = 0; i < EN; i++) if (eng_start[i]) log_eng.push_back(i);
      log_tag.push_back(int'(eng_tag));
      log_cyc.push_back(cyc_no);
      all_tags.push_back(int'(eng_tag));
    end
    @(posedge clk);
    m_step();
    cyc_no++;
    @(negedge clk);
    job_data = $urandom;
  endtask

  task automatic clear_log();
    log_eng.delete();
    log_tag.delete();
    log_cyc.delete();
  endtask

  initial begin
    int  first;
    bit  seen;
    int  sz;
    int  st0;

    rst_n = 1'b0; init_done = 1'b0; job_valid = 1'b0; job_data = '0;
    eng_busy = '0; credit_ret = 1'b0;
    m_reset();
    @(negedge clk);
    repeat (3) cyc();

    // Init gate: no launch while the reorder buffer is not initialised
    rst_n = 1'b1; job_valid = 1'b1;
    repeat (20) cyc();
    chk("init_gate_launches", log_eng.size(), 0);

    init_done = 1'b1;
    first = -1;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (log_eng.size() > 0) begin first = c; break; end
    end
    chk("init_first_latency", first, 2);
    if (log_eng.size() > 0) begin
      chk("init_first_eng", log_eng[0], 0);
      chk("init_first_tag", log_tag[0], 0);
    end

    // Round-robin across free engines, credits returned promptly
    for (int c = 0; c < 60 && log_eng.size() < 8; c++) begin
      credit_ret = (m_out > 0);
      cyc();
    end
    chk("rr_count", log_eng.size(), 8);
    for (int i = 0; i < log_eng.size(); i++) begin
      chk("rr_eng", log_eng[i], i % EN);
      chk("rr_tag", log_tag[i], i);
      if (i > 0) chk("rr_spacing", log_cyc[i] - log_cyc[i-1], 2);
    end

    // Busy skip: engines 0 and 2 busy
    clear_log();
    eng_busy = 4'b0101;
    for (int c = 0; c < 60 && log_eng.size() < 6; c++) begin
      credit_ret = (m_out > 0);
      cyc();
    end
    chk("skip_count", log_eng.size(), 6);
    for (int i = 0; i < log_eng.size(); i++) chk("skip_eng", log_eng[i], (i % 2 == 0) ? 1 : 3);

    // All engines busy: no launch, stall counter climbs when enabled
    clear_log();
    eng_busy = 4'b1111;
    credit_ret = (m_out > 0);
    #1 st0 = int'(stat_stall_cnt);
    for (int c = 0; c < 10; c++) begin
      credit_ret = (m_out > 0);
      cyc();
    end
    chk("allbusy_launches", log_eng.size(), 0);
    #1;
`ifdef SHA1_TAG_DISPATCH_STAT_EN
    chk("allbusy_stall_delta", int'(stat_stall_cnt) - st0, 10);
`else
    chk("allbusy_stall_delta", int'(stat_stall_cnt) - st0, 0);
`endif

    // Credit limit
    eng_busy = '0; job_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      credit_ret = (m_out > 0);
      cyc();
    end
    credit_ret = 1'b0;
    clear_log();
    job_valid = 1'b1;
    repeat (14) cyc();
    chk("limit_launches", log_eng.size(), 4);
    #1;
    chk("limit_outstanding", outstanding, 4);
    chk("limit_ready_low", job_ready, 0);
    credit_ret = 1'b1;
    cyc();
    credit_ret = 1'b0;
    #1;
    chk("limit_after_credit", outstanding, 3);
    chk("limit_ready_back", job_ready, 1);
    cyc();
    credit_ret = 1'b1;
    cyc();
    credit_ret = 1'b0;
    #1;
    chk("limit_issue_and_credit", outstanding, 3);
    chk("limit_one_more", log_eng.size(), 5);
    repeat (8) cyc();
    chk("limit_final_launches", log_eng.size(), 6);
    chk("limit_final_outstanding", outstanding, 4);

    // Tags issued so far count up and wrap modulo 2^TW
    for (int i = 0; i < all_tags.size(); i++) chk("tag_seq", all_tags[i], i % (1 << TW));

    // Credit with nothing outstanding
    job_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      credit_ret = (m_out > 0);
      cyc();
    end
    credit_ret = 1'b0;
    #1 chk("err_before", credit_err, 0);
    credit_ret = 1'b1;
    cyc();
    credit_ret = 1'b0;
    #1;
    chk("err_set", credit_err, 1);
    chk("err_out_zero", outstanding, 0);
    repeat (3) cyc();

    // Random traffic, including init_done dropping after start-up
    for (int c = 0; c < 400; c++) begin
      job_valid  = ($urandom_range(0, 3) != 0);
      eng_busy   = EN'($urandom);
      credit_ret = (m_out > 0) && ($urandom_range(0, 2) == 0);
      init_done  = $urandom_range(0, 1);
      cyc();
    end

    // Reset while a launch is pending
    eng_busy = '0; job_valid = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (m_phase == 2) begin seen = 1; break; end
      credit_ret = (m_out > 0);
      cyc();
    end
    chk("rst_reached_issue", seen, 1);
    credit_ret = 1'b0;
    rst_n = 1'b0;
    sz = log_eng.size();
    cyc();
    chk("rst_no_launch", log_eng.size(), sz);
    cyc();
    #1;
    chk("rst_job_ready", job_ready, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_data", eng_data, 0);
    chk("rst_eng_tag", eng_tag, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_credit_err", credit_err, 0);
    chk("rst_stat_issue", stat_issue_cnt, 0);
    chk("rst_stat_stall", stat_stall_cnt, 0);
    rst_n = 1'b1; init_done = 1'b1;
    clear_log();
    for (int c = 0; c < 10 && log_eng.size() == 0; c++) cyc();
    chk("post_rst_launch_seen", log_eng.size(), 1);
    if (log_eng.size() > 0) begin
      chk("post_rst_tag", log_tag[0], 0);
      chk("post_rst_eng", log_eng[0], 0);
    end
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
